// File: rtl/uart_tx_mmio.sv
// 8N1 UART transmitter with MMIO doorbell write; single holding register or UART_TX_FIFO_EN circular FIFO.
// Latency: doorbell edge to start-bit falling edge is one clock; frames run back to back while data is buffered.
// Backpressure: full is registered state; a doorbell while full drops the byte and sets sticky overrun.
module uart_tx_mmio #(
  parameter int CLKS_PER_BIT = 234,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       doorbell,
  input  logic       overrun_clr,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] baud_cnt, baud_d;
  logic [2:0]       bit_cnt, bit_d;
  logic [7:0]       shift, shift_d;
  logic             tx_d;
  logic             pop;
  logic             push;
  logic             buf_vld;
  logic [7:0]       buf_dat;

  // full comes from registered state only, so a same-cycle pop never admits the write
  assign push = doorbell & ~full;

`ifdef UART_TX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign buf_vld = (count != '0);
  assign buf_dat = mem[rd_ptr];
`else
  logic [7:0] hold_dat;
  logic       hold_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld <= 1'b0;
      hold_dat <= '0;
    end else begin
      if (pop) hold_vld <= 1'b0;
      if (push) begin
        hold_vld <= 1'b1;
        hold_dat <= data_in;
      end
    end
  end

  assign full    = hold_vld;
  assign buf_vld = hold_vld;
  assign buf_dat = hold_dat;
`endif

  always_comb begin
    state_d = state;
    baud_d  = baud_cnt;
    bit_d   = bit_cnt;
    shift_d = shift;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (buf_vld) begin
          pop     = 1'b1;
          shift_d = buf_dat;
          bit_d   = '0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = shift >> 1;
          bit_d   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_d = '0;
          if (buf_vld) begin
            pop     = 1'b1;
            shift_d = buf_dat;
            bit_d   = '0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered from the next state so the start bit appears on the pop edge
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_cnt  <= bit_d;
      shift    <= shift_d;
      tx       <= tx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                overrun <= 1'b0;
    else if (doorbell && full) overrun <= 1'b1;
    else if (overrun_clr)      overrun <= 1'b0;
  end

  assign busy = (state != IDLE) | buf_vld;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: a line monitor records each frame, the main sequence checks it.
module tb_uart_tx_mmio;

  localparam int CPB   = 234;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       doorbell = 1'b0;
  logic       overrun_clr = 1'b0;
  logic       tx, busy, full, overrun;

  uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .doorbell(doorbell),
    .overrun_clr(overrun_clr), .tx(tx), .busy(busy), .full(full), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int wcyc   = 0;

  // frame vectors: bit 0 = start, bits 8:1 = data, bit 9 = stop
  logic [9:0] q_first[$];
  logic [9:0] q_last[$];
  int         q_start[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Samples first and last cycle of every bit; a reset mid-frame discards the frame
  initial begin
    logic [9:0] fv, lv;
    int st;
    bit ab;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        st = cyc;
        ab = 1'b0;
        fv = '0;
        lv = '0;
        for (int i = 0; i < FRAME; i++) begin
          if (i > 0) @(negedge clk);
          if (!rst_n) begin
            ab = 1'b1;
            break;
          end
          if (i % CPB == 0)       fv[i / CPB] = tx;
          if (i % CPB == CPB - 1) lv[i / CPB] = tx;
        end
        if (!ab) begin
          q_first.push_back(fv);
          q_last.push_back(lv);
          q_start.push_back(st);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic clear_q();
    q_first.delete();
    q_last.delete();
    q_start.delete();
  endtask

  task automatic wr(input logic [7:0] d);
    @(negedge clk);
    doorbell = 1'b1;
    data_in  = d;
    @(negedge clk);
    doorbell = 1'b0;
    wcyc     = cyc;
  endtask

  task automatic wr_when_ready(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (full !== 1'b0 && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    chk("full_wait", full, 1'b0);
    doorbell = 1'b1;
    data_in  = d;
    @(negedge clk);
    doorbell = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", busy, 1'b0);
  endtask

  task automatic chk_frame(input string tag, input int i, input logic [7:0] d);
    logic [9:0] e;
    e = {1'b1, d, 1'b0};
    chk($sformatf("%s_first%0d", tag, i), q_first[i], e);
    chk($sformatf("%s_last%0d", tag, i), q_last[i], e);
    if (i > 0) chk($sformatf("%s_contig%0d", tag, i), q_start[i] - q_start[i-1], FRAME);
  endtask

  initial begin
    int c0;

    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single 0x55 frame: latency, alternating bit widths, busy fall time
    clear_q();
    wr(8'h55);
    c0 = wcyc;
    repeat (2340) @(negedge clk);
    chk("t1_busy_last_stop", busy, 1'b1);
    @(negedge clk);
    chk("t1_busy_fall", busy, 1'b0);
    chk("t1_tx_idle", tx, 1'b1);
    chk("t1_nframes", q_start.size(), 1);
    chk("t1_latency", q_start[0] - c0, 1);
    chk_frame("t1", 0, 8'h55);

    // three contiguous frames
    clear_q();
    wr_when_ready(8'h41);
    wr_when_ready(8'h42);
    wr_when_ready(8'h43);
    wait_idle(4 * FRAME);
    chk("t2_nframes", q_start.size(), 3);
    chk_frame("t2", 0, 8'h41);
    chk_frame("t2", 1, 8'h42);
    chk_frame("t2", 2, 8'h43);
    chk("t2_overrun", overrun, 1'b0);

`ifdef UART_TX_FIFO_EN
    // fill the 8-deep FIFO: tenth byte dropped, set wins over clear
    clear_q();
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i == 8) chk("t3_not_full_8", full, 1'b0);
      doorbell = 1'b1;
      data_in  = i[7:0];
      if (i == 9) begin
        chk("t3_full_9", full, 1'b1);
        chk("t3_ovr_before", overrun, 1'b0);
        overrun_clr = 1'b1;
      end
      @(negedge clk);
    end
    chk("t3_ovr_set_wins", overrun, 1'b1);
    doorbell = 1'b0;
    @(negedge clk);
    chk("t3_ovr_cleared", overrun, 1'b0);
    overrun_clr = 1'b0;
    wait_idle(11 * FRAME);
    chk("t3_nframes", q_start.size(), 9);
    for (int i = 0; i < 9; i++) chk_frame("t3", i, i[7:0]);
`else
    // holding register: write during the pop cycle is dropped, set wins over clear
    clear_q();
    @(negedge clk);
    doorbell = 1'b1;
    data_in  = 8'hA5;
    @(negedge clk);
    chk("t3_full_a5", full, 1'b1);
    data_in     = 8'h11;
    overrun_clr = 1'b1;
    @(negedge clk);
    chk("t3_ovr_set_wins", overrun, 1'b1);
    chk("t3_popped", full, 1'b0);
    doorbell = 1'b0;
    @(negedge clk);
    chk("t3_ovr_cleared", overrun, 1'b0);
    overrun_clr = 1'b0;
    doorbell    = 1'b1;
    data_in     = 8'h3C;
    @(negedge clk);
    chk("t3_full_3c", full, 1'b1);
    data_in = 8'h99;
    @(negedge clk);
    chk("t3_ovr_99", overrun, 1'b1);
    doorbell = 1'b0;
    wait_idle(3 * FRAME);
    chk("t3_nframes", q_start.size(), 2);
    chk_frame("t3", 0, 8'hA5);
    chk_frame("t3", 1, 8'h3C);
`endif

    // reset during data bit 3 of 0xF0, then a clean 0x0F frame
    clear_q();
    wr(8'hF0);
    c0 = wcyc;
    repeat (1 + 4 * CPB + 100) @(negedge clk);
    chk("t4_bit3_low", tx, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_tx", tx, 1'b1);
    chk("t4_rst_busy", busy, 1'b0);
    chk("t4_rst_overrun", overrun, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    wr(8'h0F);
    c0 = wcyc;
    wait_idle(2 * FRAME);
    chk("t4_nframes", q_start.size(), 1);
    chk("t4_latency", q_start[0] - c0, 1);
    chk_frame("t4", 0, 8'h0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
